s_axi_reg_bank: RTL
===================

# s_axi_reg_bank

Parametrised AXI4 slave register bank, the successor to the fixed four-register AXI slave: NUM_REGS registers of DATA_W bits with byte-strobe writes, independent AW/W acceptance, ID echo, a full read channel and SLVERR on out-of-range or burst accesses. Sits between the AXI interconnect and the counter core. All register contents are exported flat on `regs_o` for the counter core to use as control/compare values.

## Interface
- DATA_W, 32: register and bus data width; multiple of 8.
- ADDR_W, 32: AXI address width.
- ID_W, 4: AXI ID width.
- NUM_REGS, 8: number of registers; power of two, ≥2.
- Derived values: STRB_W = DATA_W/8; LSB = log2(STRB_W); IDX_W = log2(NUM_REGS).

- clk, in, 1: clock; all state changes on the rising edge.
- areset, in, 1: reset; one clock, asynchronous and active-high.
- awid_i / awaddr_i / awvalid_i, in, ID_W / ADDR_W / 1: write address channel.
- awready_o, out, 1: write address ready.
- wdata_i / wstrb_i / wlast_i / wvalid_i, in, DATA_W / STRB_W / 1 / 1: write data channel.
- wready_o, out, 1: write data ready.
- bid_o / bresp_o / bvalid_o, out, ID_W / 2 / 1: write response channel.
- bready_i, in, 1: write response ready.
- arid_i / araddr_i / arvalid_i, in, ID_W / ADDR_W / 1: read address channel.
- arready_o, out, 1: read address ready.
- rid_o / rdata_o / rresp_o / rlast_o / rvalid_o, out, ID_W / DATA_W / 2 / 1 / 1: read data channel.
- rready_i, in, 1: read data ready.
- regs_o, out, NUM_REGS*DATA_W: register contents; register k occupies bits [k*DATA_W +: DATA_W].

## Operation
- Register index = addr[LSB +: IDX_W]. Any address bit above LSB+IDX_W set → out of range. Low LSB bits are ignored.
- Write path uses two holding slots, AW (id, addr) and W (data, strb, last), filled independently.
  - awready_o = !aw_full && !bvalid_o.
  - wready_o = !w_full && !bvalid_o.
- Commit happens in the cycle where both slots are full. In that cycle:
  - If in range and last = 1: each byte lane j with strb[j] = 1 updates reg[idx][8j+:8]. bresp = 2'b00 (OKAY).
  - Otherwise: no register change. bresp = 2'b10 (SLVERR).
  - The slots clear, bvalid_o is set and bid_o = held id.
- bvalid_o holds until bready_i is sampled high. Only one write is outstanding at a time.
- Read path: arready_o = !rvalid_o. On the AR handshake:
  - rdata_o is registered from reg[idx], or 0 if out of range.
  - rresp_o = OKAY or SLVERR respectively; rid_o = arid_i; rlast_o = 1; rvalid_o = 1.
- rvalid_o and all r* outputs hold stable until rready_i is sampled high.
- Read and write are fully independent. Same-edge AR handshake and write commit to the same register → read returns the pre-write value.
- wstrb = 0 with valid in-range address → OKAY, no change.
- rlast_o is always 1 when rvalid_o = 1.

## Timing
- While areset is high:
  - all registers and regs_o = 0.
  - bvalid_o = rvalid_o = 0; bid_o, bresp_o, rid_o, rdata_o, rresp_o, rlast_o = 0.
  - awready_o, wready_o, arready_o forced 0.
- First cycle after reset release: awready_o = wready_o = arready_o = 1.
- Reset asserted mid-transaction discards held AW/W and pending B/R responses. No response is ever issued for them.
- Write, AW and W handshaking on the same edge E:
  - E+1: commit; register and regs_o updated; bvalid_o = 1.
  - awready_o/wready_o stay 0 until the edge after the B handshake.
- AW and W on different edges: commit occurs on the edge after the later handshake.
- A second W (or AW) arriving while its slot is full is stalled (ready = 0) until the B handshake completes.
- Read: AR handshake on edge E → rvalid_o = 1 after E. Back-to-back reads give one read per 2 cycles when rready_i is held high.
- B handshake at edge E → ready outputs return to 1 after E.

## Test plan
- Reset, then AW+W same cycle: addr 0x4, data 0xDEADBEEF, strb 0xF → bresp 00, bid echoed; a later read of 0x4 returns 0xDEADBEEF with matching rid and rlast = 1.
- Strobe merge: reg2 = 0x11223344, then write 0xAABBCCDD to 0x8 with strb 0b0101 → read returns 0x11BB33DD.
- W two cycles before AW, with bready_i held low 3 cycles → commit the edge after AW; bvalid_o held; awready_o/wready_o stay 0 until the B handshake.
- Out of range: write to 0x20 (NUM_REGS = 8) → SLVERR, no register changes; read of 0x20 → rdata 0, rresp 10. Write with wlast_i = 0 → SLVERR, register unchanged.
- Same-edge read and write commit to reg1 (old 0x5, new 0x9) → read returns 0x5; the next read returns 0x9; regs_o slice 1 = 0x9.
- Assert areset while bvalid_o and rvalid_o are pending → all outputs and regs_o go to 0 immediately; no response is issued after release.

Source files
------------

// File: rtl/s_axi_reg_bank.sv
// AXI4 slave register bank: NUM_REGS x DATA_W registers with byte-strobe writes,
// independent AW/W holding slots, ID echo, and SLVERR on out-of-range or burst access.
module s_axi_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [ID_W-1:0]            awid_i,
  input  logic [ADDR_W-1:0]          awaddr_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [ID_W-1:0]            bid_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [ID_W-1:0]            arid_i,
  input  logic [ADDR_W-1:0]          araddr_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [ID_W-1:0]            rid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rlast_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> (LSB + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[LSB +: IDX_W];
  endfunction

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] nxt,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int j = 0; j < STRB_W; j++) begin
      if (strb[j]) res[8*j +: 8] = nxt[8*j +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  // AW slot keeps only the decoded index and range flag; W slot keeps the beat
  logic              aw_full;
  logic [ID_W-1:0]   aw_id;
  logic [IDX_W-1:0]  aw_idx;
  logic              aw_ok;
  logic              w_full;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;

  logic commit;
  logic commit_ok;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic unused_addr_bits;

  assign awready_o = !areset && !aw_full && !bvalid_o;
  assign wready_o  = !areset && !w_full && !bvalid_o;
  assign arready_o = !areset && !rvalid_o;

  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign ar_hs     = arvalid_i && arready_o;
  assign commit    = aw_full && w_full;
  assign commit_ok = aw_ok && w_last;

  assign unused_addr_bits = ^{awaddr_i, araddr_i};

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      aw_full  <= 1'b0;
      aw_id    <= '0;
      aw_idx   <= '0;
      aw_ok    <= 1'b0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      w_last   <= 1'b0;
      bvalid_o <= 1'b0;
      bid_o    <= '0;
      bresp_o  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_id   <= awid_i;
        aw_idx  <= addr_idx(awaddr_i);
        aw_ok   <= addr_in_range(awaddr_i);
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= wdata_i;
        w_strb <= wstrb_i;
        w_last <= wlast_i;
      end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_o <= 1'b1;
        bid_o    <= aw_id;
        bresp_o  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_o && bready_i) begin
        bvalid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (commit && commit_ok) begin
      regs[aw_idx] <= strb_merge(regs[aw_idx], w_data, w_strb);
    end
  end

  // Read samples the pre-commit register value when AR and commit share an edge
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rvalid_o <= 1'b0;
      rid_o    <= '0;
      rdata_o  <= '0;
      rresp_o  <= '0;
      rlast_o  <= 1'b0;
    end else if (ar_hs) begin
      rvalid_o <= 1'b1;
      rid_o    <= arid_i;
      rlast_o  <= 1'b1;
      if (addr_in_range(araddr_i)) begin
        rdata_o <= regs[addr_idx(araddr_i)];
        rresp_o <= RESP_OKAY;
      end else begin
        rdata_o <= '0;
        rresp_o <= RESP_SLVERR;
      end
    end else if (rvalid_o && rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule
